// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and immediate decoders used by the fetch front end.
package riscv_pkg;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] INVALID_PC = 32'hFFFF_FFFF;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // J-type immediate, sign-extended, bit 0 always zero.
  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // B-type immediate, sign-extended, bit 0 always zero.
  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Bundle of the fetch unit's memory, decode and execute-redirect signals.
//
// Handshake rule for both channels (mem request, decode head): a transfer
// happens on a rising clk edge exactly when valid and ready are both high.
// valid never depends on ready; ready may depend on valid. Responses carry
// no ready: the fetch unit always accepts i_mem_rsp_valid.
interface fetch_queue_unit_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);

  logic            o_mem_req_valid;
  logic [XLEN-1:0] o_mem_req_addr;
  logic            i_mem_req_ready;
  logic            i_mem_rsp_valid;
  logic [ILEN-1:0] i_mem_rsp_inst;
  logic            o_du_valid;
  logic [ILEN-1:0] o_du_inst;
  logic [XLEN-1:0] o_du_addr;
  logic            o_du_pred_taken;
  logic            i_du_ready;
  logic            i_exec_flush;
  logic [XLEN-1:0] i_exec_pc;
  logic            o_exec_align_error;

  // The fetch unit itself.
  modport master (
    output o_mem_req_valid, o_mem_req_addr,
    input  i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_inst,
    output o_du_valid, o_du_inst, o_du_addr, o_du_pred_taken,
    input  i_du_ready, i_exec_flush, i_exec_pc,
    output o_exec_align_error
  );

  // Memory, decode and execute seen from the outside.
  modport slave (
    input  o_mem_req_valid, o_mem_req_addr,
    output i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_inst,
    input  o_du_valid, o_du_inst, o_du_addr, o_du_pred_taken,
    output i_du_ready, i_exec_flush, i_exec_pc,
    input  o_exec_align_error
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head read and a clear input.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO may still take a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: issues PC-ordered fetches, tags them with
// their address, buffers returned words for Decode and statically predicts
// JAL and backward branches. Wrong-path responses are counted and dropped.
module fetch_queue_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter int              ILEN    = 32,
  parameter int              DEPTH   = 4,
  parameter logic [XLEN-1:0] INIT_PC = '0,
  parameter logic [XLEN-1:0] TRAP_PC = XLEN'(32'h0000_0004)
) (
  input logic               clk,
  input logic               rstn,
  fetch_queue_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = 1 + XLEN + ILEN;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop;
  logic            align_err;

  logic [CW-1:0]   q_count;
  logic            q_empty;
  logic            q_full;
  logic [QW-1:0]   q_head;
  logic [CW-1:0]   inflight;
  logic            tag_empty;
  logic            tag_full;
  logic [XLEN-1:0] tag_addr;

  logic            credit_ok;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_fire;
  logic            rsp_keep;
  logic [CW-1:0]   inflight_next;
  logic [6:0]      opcode;
  logic            is_jal;
  logic            is_bneg;
  logic            pred_taken;
  logic [31:0]     imm;
  logic [XLEN-1:0] target;
  logic [QW-1:0]   q_wdata;

  // Every request reserves a queue slot up front, so the queue cannot
  // overflow no matter how responses bunch up.
  assign credit_ok = ({1'b0, q_count} + {1'b0, inflight}) < (CW+1)'(DEPTH);
  assign req_valid = rstn & credit_ok & ~tag_full & ~q_full;
  assign req_fire  = req_valid & bus.i_mem_req_ready;
  assign rsp_fire  = bus.i_mem_rsp_valid & ~tag_empty;

  assign inflight_next = inflight + CW'(req_fire) - CW'(rsp_fire);
  assign rsp_keep      = rsp_fire & (drop == '0) & ~bus.i_exec_flush;

  assign opcode     = bus.i_mem_rsp_inst[6:0];
  assign is_jal     = (opcode == OPC_JAL);
  assign is_bneg    = (opcode == OPC_BRANCH) & bus.i_mem_rsp_inst[31];
  assign pred_taken = rsp_keep & (is_jal | is_bneg);
  assign imm        = is_jal ? imm_j(bus.i_mem_rsp_inst) : imm_b(bus.i_mem_rsp_inst);
  assign target     = tag_addr + XLEN'($signed(imm));
  assign q_wdata    = {pred_taken, tag_addr, bus.i_mem_rsp_inst};

  assign bus.o_mem_req_valid    = req_valid;
  assign bus.o_mem_req_addr     = pc;
  assign bus.o_du_valid         = ~q_empty;
  assign bus.o_du_inst          = q_empty ? ILEN'(NOP) : q_head[ILEN-1:0];
  assign bus.o_du_addr          = q_empty ? {XLEN{1'b1}} : q_head[ILEN +: XLEN];
  assign bus.o_du_pred_taken    = ~q_empty & q_head[QW-1];
  assign bus.o_exec_align_error = align_err;

  // Address tags follow requests one-for-one; the tag count is the number
  // of outstanding requests. Never flushed: dropped responses still pop it.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (req_fire),
    .pop   (rsp_fire),
    .flush (1'b0),
    .wdata (pc),
    .rdata (tag_addr),
    .full  (tag_full),
    .empty (tag_empty),
    .count (inflight)
  );

  // Instruction queue feeding Decode, entries are {pred, addr, inst}.
  sync_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_inst_q (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rsp_keep),
    .pop   (bus.i_du_ready),
    .flush (bus.i_exec_flush),
    .wdata (q_wdata),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // PC selection (flush > predicted redirect > sequential) and drop count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc        <= INIT_PC;
      drop      <= '0;
      align_err <= 1'b0;
    end else if (bus.i_exec_flush) begin
      drop <= inflight_next;
      if (bus.i_exec_pc[1:0] != 2'b00) begin
        pc        <= TRAP_PC;
        align_err <= 1'b1;
      end else begin
        pc        <= bus.i_exec_pc;
        align_err <= 1'b0;
      end
    end else if (pred_taken) begin
      pc   <= target;
      drop <= inflight_next;
    end else begin
      if (req_fire) pc <= pc + XLEN'(4);
      if (rsp_fire && drop != '0) drop <= drop - 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: random-latency in-order memory, random Decode
// back-pressure and redirects. Expected Decode stream is the architectural
// program walk from each restart point.
module tb_fetch_queue_unit;
  import riscv_pkg::*;

  localparam int          XLEN    = 32;
  localparam int          ILEN    = 32;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] INIT_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC = 32'h0000_0004;
  localparam int          K       = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  fetch_queue_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  fetch_queue_unit #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .INIT_PC(INIT_PC), .TRAP_PC(TRAP_PC)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- program image ----------------
  logic [31:0] imem [logic [31:0]];
  bit          itak [logic [31:0]];
  logic [31:0] itgt [logic [31:0]];

  function automatic logic [31:0] enc_jal(input int off);
    logic [20:0] im;
    im = off[20:0];
    return {im[20], im[10:1], im[11], im[19:12], 5'd1, OPC_JAL};
  endfunction

  function automatic logic [31:0] enc_br(input int off);
    logic [12:0] im;
    im = off[12:0];
    return {im[12], im[10:5], 5'd2, 5'd1, 3'b000, im[4:1], im[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_alu();
    logic [31:0] rr;
    rr = $urandom;
    return {rr[31:15], 3'b000, rr[11:7], 7'b0010011};
  endfunction

  task automatic set_inst(input logic [31:0] a, input logic [31:0] inst,
                          input bit tak, input logic [31:0] tgt);
    imem[a] = inst;
    itak[a] = tak;
    itgt[a] = tgt;
  endtask

  // Lazily create a random instruction the first time an address is seen.
  task automatic ensure(input logic [31:0] a);
    int r;
    int off;
    if (!imem.exists(a)) begin
      r   = $urandom_range(0, 9);
      off = 4 * int'($urandom_range(1, 16));
      if (r == 0) begin
        if ($urandom_range(0, 1) == 1) off = -off;
        set_inst(a, enc_jal(off), 1'b1, a + 32'(off));
      end else if (r == 1) begin
        set_inst(a, enc_br(off), 1'b0, 32'h0);
      end else if (r == 2) begin
        set_inst(a, enc_br(-off), 1'b1, a - 32'(off));
      end else begin
        set_inst(a, enc_alu(), 1'b0, 32'h0);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural program walk: what Decode must see after a restart.
  task automatic push_stream(input logic [31:0] start);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < K; i++) begin
      ensure(a);
      exp_q.push_back({itak[a], a, imem[a]});
      a = itak[a] ? itgt[a] : a + 32'd4;
    end
  endtask

  // ---------------- monitor (negedge sampling) ----------------
  logic        s_hs = 1'b0;
  logic        s_rsp = 1'b0;
  logic [31:0] s_addr = 32'h0;
  int          hs_count = 0;

  always @(negedge clk) begin
    s_hs   = bus.o_mem_req_valid & bus.i_mem_req_ready;
    s_addr = bus.o_mem_req_addr;
    s_rsp  = bus.i_mem_rsp_valid;
    if (s_hs) hs_count++;
    if (rstn && bus.o_du_valid && bus.i_du_ready && !bus.i_exec_flush) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL du_entry: got %h expected nothing (t=%0t)",
                 {bus.o_du_pred_taken, bus.o_du_addr, bus.o_du_inst}, $time);
      end else begin
        chk("du_entry", {bus.o_du_pred_taken, bus.o_du_addr, bus.o_du_inst}, exp_q.pop_front());
      end
    end
  end

  // ---------------- memory driver ----------------
  logic [31:0] pend_q[$];
  int          due_q[$];
  int          cyc = 0;
  bit          mem_ideal = 1'b1;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rstn) begin
      pend_q.delete();
      due_q.delete();
      bus.i_mem_req_ready = 1'b0;
      bus.i_mem_rsp_valid = 1'b0;
      bus.i_mem_rsp_inst  = 32'h0;
    end else begin
      if (s_rsp && pend_q.size() > 0) begin
        void'(pend_q.pop_front());
        void'(due_q.pop_front());
      end
      if (s_hs) begin
        pend_q.push_back(s_addr);
        due_q.push_back(mem_ideal ? cyc : cyc + int'($urandom_range(0, 3)));
      end
      bus.i_mem_req_ready = mem_ideal ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (pend_q.size() > 0 && due_q[0] <= cyc && (mem_ideal || $urandom_range(0, 3) != 0)) begin
        ensure(pend_q[0]);
        bus.i_mem_rsp_valid = 1'b1;
        bus.i_mem_rsp_inst  = imem[pend_q[0]];
      end else begin
        bus.i_mem_rsp_valid = 1'b0;
        bus.i_mem_rsp_inst  = $urandom;
      end
    end
  end

  // ---------------- decode ready driver ----------------
  int du_mode = 2;  // 0: held low, 1: random, 2: always high

  always @(posedge clk) begin
    #2;
    if (du_mode == 2)      bus.i_du_ready = 1'b1;
    else if (du_mode == 1) bus.i_du_ready = ($urandom_range(0, 2) != 0);
    else                   bus.i_du_ready = 1'b0;
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_reset(input int cycles_low);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("rst_req_valid", 65'(bus.o_mem_req_valid), 65'(0));
    chk("rst_du_valid",  65'(bus.o_du_valid), 65'(0));
    chk("rst_du_inst",   65'(bus.o_du_inst), 65'(NOP));
    chk("rst_du_addr",   65'(bus.o_du_addr), 65'(32'hFFFF_FFFF));
    chk("rst_du_pred",   65'(bus.o_du_pred_taken), 65'(0));
    chk("rst_align_err", 65'(bus.o_exec_align_error), 65'(0));
    repeat (cycles_low) @(posedge clk);
    #1;
    rstn = 1'b1;
    hs_count = 0;
    exp_q.delete();
    push_stream(INIT_PC);
    #1;
    chk("rst_req_addr", 65'(bus.o_mem_req_addr), 65'(INIT_PC));
  endtask

  task automatic do_flush(input logic [31:0] tgt, input int next_mode);
    logic [31:0] start;
    bit          mis;
    @(posedge clk); #1;
    du_mode          = 0;
    bus.i_exec_flush = 1'b1;
    bus.i_exec_pc    = tgt;
    @(posedge clk); #1;
    bus.i_exec_flush = 1'b0;
    hs_count         = 0;
    mis   = (tgt[1:0] != 2'b00);
    start = mis ? TRAP_PC : tgt;
    exp_q.delete();
    push_stream(start);
    chk("flush_req_addr",  65'(bus.o_mem_req_addr), 65'(start));
    chk("flush_du_valid",  65'(bus.o_du_valid), 65'(0));
    chk("flush_align_err", 65'(bus.o_exec_align_error), 65'(mis));
    du_mode = next_mode;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] tgt;
    bus.i_exec_flush = 1'b0;
    bus.i_exec_pc    = 32'h0;

    set_inst(32'h0, enc_alu(), 1'b0, 32'h0);
    set_inst(32'h4, enc_br(16), 1'b0, 32'h0);
    set_inst(32'h8, enc_jal(32'h40), 1'b1, 32'h48);
    set_inst(32'hC, enc_alu(), 1'b0, 32'h0);
    set_inst(32'h10, enc_br(-8), 1'b1, 32'h8);
    set_inst(32'hFFFF_FFF8, enc_alu(), 1'b0, 32'h0);
    set_inst(32'hFFFF_FFFC, enc_alu(), 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) set_inst(32'h400 + 32'(4 * i), enc_alu(), 1'b0, 32'h0);

    // Zero-wait memory, Decode always ready: 0, 4, 8 (JAL) then 0x48...
    mem_ideal = 1'b1;
    du_mode   = 2;
    do_reset(3);
    repeat (30) @(posedge clk);

    // Decode stalled: only DEPTH requests may be issued.
    do_flush(32'h400, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("credit_requests",  65'(hs_count), 65'(DEPTH));
    chk("credit_req_valid", 65'(bus.o_mem_req_valid), 65'(0));
    du_mode = 2;
    repeat (20) @(posedge clk);

    // Backward branch at 0x10 redirects to 0x8.
    do_flush(32'h10, 2);
    repeat (20) @(posedge clk);

    // Misaligned redirect goes to TRAP_PC and the error sticks.
    mem_ideal = 1'b0;
    do_flush(32'h202, 1);
    repeat (15) @(posedge clk);
    #1;
    chk("align_err_hold", 65'(bus.o_exec_align_error), 65'(1));
    do_flush(32'h300, 1);
    repeat (15) @(posedge clk);

    // PC wraps through zero.
    mem_ideal = 1'b1;
    do_flush(32'hFFFF_FFF8, 2);
    repeat (20) @(posedge clk);

    // Random redirects with random memory timing and back-pressure.
    for (int i = 0; i < 30; i++) begin
      mem_ideal = ($urandom_range(0, 1) == 1);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      do_flush(tgt, int'($urandom_range(1, 2)));
      repeat ($urandom_range(3, 40)) @(posedge clk);
    end

    // Reset in the middle of traffic.
    mem_ideal = 1'b0;
    du_mode   = 1;
    repeat (10) @(posedge clk);
    do_reset(2);
    repeat (40) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
